proc_nios2_qsys_0_ocimem_monitor: RTL and testbench

System-clock-domain consumer of the JTAG debug module's decoded command strobes and `jdo` payload. It owns the on-chip debug RAM: a 2^ADDR_W x 32 single-port synchronous RAM. It services debugger load-address, read, streaming-read and streaming-write commands, and returns `MonDReg`, `monitor_ready` and `monitor_error` upstream for shift-out. It also exposes a CPU-side slave port to the same RAM, with JTAG given fixed priority.

---
 rtl/proc_nios2_qsys_0_ocimem_monitor.sv | 81 ++++++++
 tb/tb_proc_nios2_qsys_0_ocimem_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_nios2_qsys_0_ocimem_monitor.sv
// proc_nios2_qsys_0_ocimem_monitor: JTAG debug command consumer owning the on-chip debug RAM
// Ports:
//   clk, reset                       system clock, async active-high reset
//   jdo, take_*                      decoded JTAG command strobes and payload
//   MonDReg, monitor_ready/error     JTAG read data, idle flag, sticky busy-collision flag
//   avs_*                            CPU slave port to the same RAM, JTAG has priority
module proc_nios2_qsys_0_ocimem_monitor #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest
);
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  logic              state, op_rd, rd_pend;
  logic              sa, sn, sb, acc, ld, rd, wr, we;
  logic [ADDR_W-1:0] MonAReg, a_addr, ram_addr;
  logic [31:0]       ram_din, ram_q, rd_hold;
  logic [3:0]        ram_be;
  logic [31:0]       mem [2**ADDR_W];
  logic              unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  always_comb begin
    sb = take_action_ocimem_b;
    sa = take_action_ocimem_a & ~sb;
    sn = take_no_action_ocimem_a & ~sb & ~sa;
    acc = (sa | sn | sb) & (state == IDLE);
    ld = acc & sa & jdo[35];
    rd = acc & (sn | (sa & jdo[34]));
    wr = acc & sb;
    // a load-with-read reads the freshly loaded address, not the old MonAReg
    a_addr = ld ? jdo[26 +: ADDR_W] : MonAReg;
    ram_addr = acc ? a_addr : avs_address;
    we = acc ? wr : avs_write;
    ram_be = acc ? 4'hF : avs_byteenable;
    ram_din = acc ? jdo[34:3] : avs_writedata;
    avs_waitrequest = acc & (avs_read | avs_write);
    monitor_ready = state == IDLE;
    // live RAM output in the cycle after a grant, held copy afterwards
    avs_readdata = rd_pend ? ram_q : rd_hold;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      MonAReg <= '0;
      MonDReg <= '0;
      op_rd <= 1'b0;
      monitor_error <= 1'b0;
      rd_pend <= 1'b0;
      rd_hold <= '0;
    end else begin
      state <= acc ? BUSY : IDLE;
      op_rd <= rd;
      rd_pend <= avs_read & ~acc;
      if (rd_pend) rd_hold <= ram_q;
      if (rd | wr) MonAReg <= a_addr + 1'b1;
      else if (ld) MonAReg <= a_addr;
      if (state == BUSY && op_rd) MonDReg <= ram_q;
      if (ld) monitor_error <= 1'b0;
      else if ((take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b) && state == BUSY) monitor_error <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we && ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
    ram_q <= mem[ram_addr];
  end
endmodule

// File: tb/tb_proc_nios2_qsys_0_ocimem_monitor.sv
// tb_proc_nios2_qsys_0_ocimem_monitor: directed plus randomized check of the debug RAM monitor
module tb_proc_nios2_qsys_0_ocimem_monitor;
  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        act_a, nact_a, act_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [256];
  logic [7:0]  ref_a;
  logic [31:0] ref_d;
  logic        ref_err;
  proc_nios2_qsys_0_ocimem_monitor #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(act_a), .take_no_action_ocimem_a(nact_a), .take_action_ocimem_b(act_b),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [37:0] ja(input logic ld, input logic rd, input logic [7:0] a);
    ja = '0;
    ja[35] = ld;
    ja[34] = rd;
    ja[33:26] = a;
  endfunction
  function automatic logic [37:0] jb(input logic [31:0] d);
    jb = '0;
    jb[34:3] = d;
  endfunction
  task automatic model(input logic a, input logic n, input logic b, input logic [37:0] j);
    if (b) begin
      ref_mem[ref_a] = j[34:3];
      ref_a++;
    end else if (a) begin
      if (j[35]) begin
        ref_a = j[33:26];
        ref_err = 1'b0;
      end
      if (j[34]) begin
        ref_d = ref_mem[ref_a];
        ref_a++;
      end
    end else if (n) begin
      ref_d = ref_mem[ref_a];
      ref_a++;
    end
  endtask
  task automatic jt(input logic a, input logic n, input logic b, input logic [37:0] j, input string tag);
    act_a = a;
    nact_a = n;
    act_b = b;
    jdo = j;
    step;
    act_a = 0;
    nact_a = 0;
    act_b = 0;
    jdo = '0;
    chk({tag, " ready_n1"}, 32'(monitor_ready), 32'd0);
    step;
    model(a, n, b, j);
    chk({tag, " ready_n2"}, 32'(monitor_ready), 32'd1);
    chk({tag, " mondreg"}, MonDReg, ref_d);
    chk({tag, " error"}, 32'(monitor_error), 32'(ref_err));
  endtask
  task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address = a;
    avs_writedata = d;
    avs_byteenable = be;
    avs_write = 1;
    #1;
    chk("cpu_wr wait", 32'(avs_waitrequest), 32'd0);
    step;
    avs_write = 0;
    for (int i = 0; i < 4; i++) if (be[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
  endtask
  task automatic cpu_rd(input logic [7:0] a, input string tag);
    avs_address = a;
    avs_read = 1;
    step;
    avs_read = 0;
    avs_address = 8'($urandom);
    chk({tag, " rdata"}, avs_readdata, ref_mem[a]);
    step;
    chk({tag, " rhold"}, avs_readdata, ref_mem[a]);
  endtask
  initial begin
    logic [7:0] ra;
    reset = 1;
    jdo = '0;
    act_a = 0;
    nact_a = 0;
    act_b = 0;
    avs_address = 0;
    avs_read = 0;
    avs_write = 0;
    avs_writedata = 0;
    avs_byteenable = 0;
    ref_a = 0;
    ref_d = 0;
    ref_err = 0;
    step;
    step;
    chk("rst mondreg", MonDReg, 32'd0);
    chk("rst ready", 32'(monitor_ready), 32'd1);
    chk("rst error", 32'(monitor_error), 32'd0);
    chk("rst rdata", avs_readdata, 32'd0);
    chk("rst wait", 32'(avs_waitrequest), 32'd0);
    reset = 0;
    step;
    for (int i = 0; i < 256; i++) cpu_wr(8'(i), $urandom, 4'hF);
    jt(1, 0, 0, ja(1, 0, 8'h10), "load10");
    chk("load10 areg", 32'(dut.MonAReg), 32'h10);
    jt(0, 0, 1, jb(32'hA5A5_0001), "wr1");
    step;
    jt(0, 0, 1, jb(32'hA5A5_0002), "wr2");
    step;
    jt(0, 0, 1, jb(32'hA5A5_0003), "wr3");
    jt(1, 0, 0, ja(1, 1, 8'h10), "ldrd10");
    chk("ldrd10 value", MonDReg, 32'hA5A5_0001);
    jt(0, 1, 0, '0, "srd1");
    chk("srd1 value", MonDReg, 32'hA5A5_0002);
    jt(0, 1, 0, '0, "srd2");
    chk("srd2 value", MonDReg, 32'hA5A5_0003);
    jt(1, 0, 0, ja(1, 0, 8'hFF), "loadff");
    jt(0, 0, 1, jb(32'hDEAD_BEEF), "wrff");
    jt(0, 0, 1, jb(32'h1234_5678), "wr00");
    cpu_rd(8'hFF, "wrap ff");
    chk("wrap ff value", avs_readdata, 32'hDEAD_BEEF);
    cpu_rd(8'h00, "wrap 00");
    chk("wrap 00 value", avs_readdata, 32'h1234_5678);
    act_a = 1;
    jdo = ja(1, 0, 8'h30);
    step;
    act_a = 0;
    act_b = 1;
    jdo = jb(32'h7777_7777);
    step;
    act_b = 0;
    jdo = '0;
    model(1, 0, 0, ja(1, 0, 8'h30));
    ref_err = 1;
    chk("collide error", 32'(monitor_error), 32'd1);
    chk("collide ready", 32'(monitor_ready), 32'd1);
    jt(1, 0, 0, ja(0, 0, 8'h00), "err keep");
    jt(1, 0, 0, ja(1, 0, 8'h30), "err clear");
    cpu_rd(8'h30, "ignored wr");
    avs_address = 8'h10;
    avs_read = 1;
    act_a = 1;
    jdo = ja(1, 0, 8'h20);
    #1;
    chk("stall wait", 32'(avs_waitrequest), 32'd1);
    step;
    act_a = 0;
    jdo = '0;
    #1;
    chk("stall release", 32'(avs_waitrequest), 32'd0);
    step;
    avs_read = 0;
    model(1, 0, 0, ja(1, 0, 8'h20));
    chk("stall rdata", avs_readdata, 32'hA5A5_0001);
    chk("stall ready", 32'(monitor_ready), 32'd1);
    cpu_wr(8'h40, 32'h0, 4'hF);
    cpu_wr(8'h40, 32'hFFFF_FFFF, 4'b0011);
    cpu_rd(8'h40, "be");
    chk("be value", avs_readdata, 32'h0000_FFFF);
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 5))
        0: jt(1, 0, 0, ja(1'($urandom), 1'($urandom), 8'($urandom)), "rnd a");
        1: jt(0, 1, 0, '0, "rnd n");
        2: jt(1'($urandom), 1'($urandom), 1, jb($urandom), "rnd b");
        3: jt(1, 1, 0, ja(1'($urandom), 1'($urandom), 8'($urandom)), "rnd an");
        4: cpu_wr(8'($urandom), $urandom, 4'($urandom));
        default: cpu_rd(8'($urandom), "rnd cpu");
      endcase
    end
    ra = ref_a;
    jt(1, 0, 0, ja(1, 1, ra), "pre rst");
    ra = ref_a;
    nact_a = 1;
    step;
    nact_a = 0;
    reset = 1;
    #1;
    chk("midrst mondreg", MonDReg, 32'd0);
    chk("midrst ready", 32'(monitor_ready), 32'd1);
    chk("midrst error", 32'(monitor_error), 32'd0);
    chk("midrst rdata", avs_readdata, 32'd0);
    step;
    reset = 0;
    ref_a = 0;
    ref_d = 0;
    ref_err = 0;
    step;
    cpu_rd(ra, "post rst cpu");
    jt(1, 0, 0, ja(1, 1, ra), "post rst jtag");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
